// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_ctrl
// Purpose  : Register-file access controller. It keeps a 32-entry scoreboard
//            of pending writes and stalls issue on RAW/WAW hazards. It drives
//            registered read selects for both RF read ports. A round-robin
//            arbiter shares the single RF write port between the ALU (wb0)
//            and MEM (wb1) writeback sources.
// Ports    : clk, rst_n              clock, async active-low reset
//            iss_*                   issue handshake and operand/dest regs
//            rd_valid, rd_sel_a/b    registered read selects (one cycle)
//            wb0_*, wb1_*            writeback handshakes (ALU, MEM)
//            rf_we/waddr/wdata       registered RF write port
//            busy_vec, idle, err     scoreboard, empty flag, sticky error
// Revision : 1.0 - initial release
// ============================================================================
module rf_access_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [4:0]    iss_rs,
  input  logic [4:0]    iss_rt,
  input  logic [4:0]    iss_rd,
  input  logic          iss_we,
  output logic          rd_valid,
  output logic [4:0]    rd_sel_a,
  output logic [4:0]    rd_sel_b,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  logic [4:0]    wb0_rd,
  input  logic [DW-1:0] wb0_data,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  logic [4:0]    wb1_rd,
  input  logic [DW-1:0] wb1_data,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [31:0]   busy_vec,
  output logic          idle,
  output logic          err
);

  logic [31:0]   busy_q, busy_d;
  logic          rd_valid_q, rd_valid_d;
  logic [4:0]    rd_sel_a_q, rd_sel_a_d;
  logic [4:0]    rd_sel_b_q, rd_sel_b_d;
  logic          ptr_q, ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          err_q, err_d;

  logic          hazard;
  logic          accept;
  logic          grant0, grant1, grant_any;
  logic [4:0]    g_rd;
  logic [DW-1:0] g_data;

  always_comb begin
    hazard = ((iss_rs != 5'd0) && busy_q[iss_rs]) ||
             ((iss_rt != 5'd0) && busy_q[iss_rt]) ||
             (iss_we && (iss_rd != 5'd0) && busy_q[iss_rd]);
    accept = iss_valid && !hazard;

    // A lone requester always wins; on contention the pointer decides.
    grant0    = wb0_valid && (!wb1_valid || !ptr_q);
    grant1    = wb1_valid && (!wb0_valid ||  ptr_q);
    grant_any = grant0 || grant1;
    g_rd      = grant1 ? wb1_rd   : wb0_rd;
    g_data    = grant1 ? wb1_data : wb0_data;

    rd_valid_d = accept;
    rd_sel_a_d = accept ? iss_rs : rd_sel_a_q;
    rd_sel_b_d = accept ? iss_rt : rd_sel_b_q;

    busy_d = busy_q;
    if (accept && iss_we && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    // Clear is applied after set so it wins if both hit the same register.
    if (grant_any && (g_rd != 5'd0)) begin
      busy_d[g_rd] = 1'b0;
    end
    busy_d[0] = 1'b0;

    err_d = err_q || (grant_any && (g_rd != 5'd0) && !busy_q[g_rd]);

    ptr_d = ptr_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end

    // Writes to r0 are accepted but never strobe the RF.
    rf_we_d    = grant_any && (g_rd != 5'd0);
    rf_waddr_d = grant_any ? g_rd   : rf_waddr_q;
    rf_wdata_d = grant_any ? g_data : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_a_q <= '0;
      rd_sel_b_q <= '0;
      ptr_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_sel_a_q <= rd_sel_a_d;
      rd_sel_b_q <= rd_sel_b_d;
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign iss_ready = !hazard;
  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign rd_valid  = rd_valid_q;
  assign rd_sel_a  = rd_sel_a_q;
  assign rd_sel_b  = rd_sel_b_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_vec  = busy_q;
  assign idle      = (busy_q == 32'd0);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_access_ctrl
// Purpose  : Directed self-checking bench for rf_access_ctrl. Inputs change
//            1ns after a rising edge; outputs are checked away from the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        iss_we;
  logic        rd_valid;
  logic [4:0]  rd_sel_a, rd_sel_b;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
  logic        idle;
  logic        err;

  int total;
  int bad;

  rf_access_ctrl #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd), .iss_we(iss_we),
    .rd_valid(rd_valid), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0; iss_we = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic issue_dest(input logic [4:0] rd);
    iss_valid = 1; iss_rs = 0; iss_rt = 0; iss_rd = rd; iss_we = 1;
    step();
    iss_valid = 0; iss_we = 0; iss_rd = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_rf got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
    total++; if (rd_valid !== 1'b0 || rd_sel_a !== 5'd0 || rd_sel_b !== 5'd0 || err !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b/%0d/%0d err=%b exp=0", rd_valid, rd_sel_a, rd_sel_b, err); end
    iss_rs = 5'd5; iss_rt = 5'd31; iss_rd = 5'd7; iss_we = 1; #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", iss_ready); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_arbitration();
    issue_dest(5'd3);
    issue_dest(5'd4);
    for (int pair = 0; pair < 2; pair++) begin
      wb0_valid = 1; wb0_rd = 5'd3; wb0_data = 32'hA0A0_0000 + pair;
      wb1_valid = 1; wb1_rd = 5'd4; wb1_data = 32'hB1B1_0000 + pair;
      #1;
      total++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin bad++; $display("FAIL arb_first_ready pair=%0d got=%b%b exp=10", pair, wb0_ready, wb1_ready); end
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA0A0_0000 + pair) begin bad++; $display("FAIL arb_first_wr pair=%0d got=%b/%0d/%h exp=1/3/%h", pair, rf_we, rf_waddr, rf_wdata, 32'hA0A0_0000 + pair); end
      wb0_valid = 0;
      #1;
      total++; if (wb1_ready !== 1'b1) begin bad++; $display("FAIL arb_second_ready pair=%0d got=%b exp=1", pair, wb1_ready); end
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hB1B1_0000 + pair) begin bad++; $display("FAIL arb_second_wr pair=%0d got=%b/%0d/%h exp=1/4/%h", pair, rf_we, rf_waddr, rf_wdata, 32'hB1B1_0000 + pair); end
      wb1_valid = 0;
      if (pair == 0) begin
        issue_dest(5'd3);
        issue_dest(5'd4);
      end
    end
    total++; if (busy_vec !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL arb_end got=%h err=%b exp=0 err=0", busy_vec, err); end
  endtask

  task automatic test_raw();
    iss_valid = 1; iss_rs = 0; iss_rt = 0; iss_rd = 5'd5; iss_we = 1;
    #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL raw_prod_ready got=%b exp=1", iss_ready); end
    step();
    total++; if (busy_vec !== 32'h20 || idle !== 1'b0) begin bad++; $display("FAIL raw_busy got=%h idle=%b exp=20 idle=0", busy_vec, idle); end
    iss_rs = 5'd5; iss_rt = 5'd2; iss_rd = 0; iss_we = 0;
    #1;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b exp=0", iss_ready); end
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL raw_no_accept got=%b exp=0", rd_valid); end
    wb0_valid = 1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    total++; if (wb0_ready !== 1'b1 || iss_ready !== 1'b0) begin bad++; $display("FAIL raw_grant got=%b ready=%b exp=1 ready=0", wb0_ready, iss_ready); end
    step();
    wb0_valid = 0;
    #1;
    total++; if (iss_ready !== 1'b1 || busy_vec !== 32'h0) begin bad++; $display("FAIL raw_release got=%b busy=%h exp=1 busy=0", iss_ready, busy_vec); end
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    step();
    iss_valid = 0;
    total++; if (rd_valid !== 1'b1 || rd_sel_a !== 5'd5 || rd_sel_b !== 5'd2) begin bad++; $display("FAIL raw_consumer got=%b/%0d/%0d exp=1/5/2", rd_valid, rd_sel_a, rd_sel_b); end
    total++; if (rf_we !== 1'b0 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_we_drop got=%b/%h exp=0/deadbeef", rf_we, rf_wdata); end
    step();
    total++; if (rd_valid !== 1'b0 || rd_sel_a !== 5'd5 || rd_sel_b !== 5'd2) begin bad++; $display("FAIL raw_sel_hold got=%b/%0d/%0d exp=0/5/2", rd_valid, rd_sel_a, rd_sel_b); end
  endtask

  task automatic test_waw();
    issue_dest(5'd7);
    total++; if (busy_vec !== 32'h80) begin bad++; $display("FAIL waw_set got=%h exp=80", busy_vec); end
    iss_valid = 1; iss_rs = 0; iss_rt = 0; iss_rd = 5'd7; iss_we = 1;
    #1;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b exp=0", iss_ready); end
    step();
    total++; if (rd_valid !== 1'b0 || busy_vec !== 32'h80) begin bad++; $display("FAIL waw_held got=%b busy=%h exp=0 busy=80", rd_valid, busy_vec); end
    wb1_valid = 1; wb1_rd = 5'd7; wb1_data = 32'h7777_7777;
    step();
    wb1_valid = 0;
    #1;
    total++; if (busy_vec !== 32'h0 || iss_ready !== 1'b1) begin bad++; $display("FAIL waw_clear got=%h ready=%b exp=0 ready=1", busy_vec, iss_ready); end
    step();
    iss_valid = 0; iss_we = 0; iss_rd = 0;
    total++; if (busy_vec !== 32'h80 || rd_valid !== 1'b1) begin bad++; $display("FAIL waw_reaccept got=%h rdv=%b exp=80 rdv=1", busy_vec, rd_valid); end
    wb0_valid = 1; wb0_rd = 5'd7; wb0_data = 32'h7;
    step();
    wb0_valid = 0;
    total++; if (busy_vec !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL waw_end got=%h err=%b exp=0 err=0", busy_vec, err); end
  endtask

  task automatic test_r0();
    issue_dest(5'd0);
    total++; if (busy_vec !== 32'h0 || rd_valid !== 1'b1) begin bad++; $display("FAIL r0_issue got=%h rdv=%b exp=0 rdv=1", busy_vec, rd_valid); end
    wb1_valid = 1; wb1_rd = 5'd0; wb1_data = 32'h1234_5678;
    #1;
    total++; if (wb1_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", wb1_ready); end
    step();
    wb1_valid = 0;
    total++; if (rf_we !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL r0_discard got we=%b err=%b exp=0/0", rf_we, err); end
  endtask

  task automatic test_spurious();
    wb0_valid = 1; wb0_rd = 5'd9; wb0_data = 32'h9999_0009;
    step();
    wb0_valid = 0;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || err !== 1'b1) begin bad++; $display("FAIL spur_write got=%b/%0d err=%b exp=1/9 err=1", rf_we, rf_waddr, err); end
    step(); step();
    total++; if (err !== 1'b1 || busy_vec !== 32'h0) begin bad++; $display("FAIL spur_sticky got err=%b busy=%h exp=1/0", err, busy_vec); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1; iss_rs = 0; iss_rt = 0; iss_rd = 5'd5; iss_we = 1;
    wb1_valid = 1; wb1_rd = 5'd12; wb1_data = 32'hCAFE_F00D;
    step();
    clear_inputs();
    total++; if (busy_vec !== 32'h20 || rf_we !== 1'b1) begin bad++; $display("FAIL mid_setup got=%h we=%b exp=20 we=1", busy_vec, rf_we); end
    #2;
    rst_n = 0;
    #1;
    total++; if (rf_we !== 1'b0 || busy_vec !== 32'h0 || idle !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL mid_reset got we=%b busy=%h idle=%b err=%b exp=0/0/1/0", rf_we, busy_vec, idle, err); end
    total++; if (rd_valid !== 1'b0 || rd_sel_a !== 5'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin bad++; $display("FAIL mid_regs got=%b/%0d/%0d/%h exp=0", rd_valid, rd_sel_a, rf_waddr, rf_wdata); end
    iss_rs = 5'd5; iss_rt = 5'd9; iss_rd = 5'd5; iss_we = 1; #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", iss_ready); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arbitration();
    test_raw();
    test_waw();
    test_r0();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Register-file access controller for the pipelined CPU. It sequences the 32x32 register file around the read-select multiplexer: a 32-entry scoreboard stalls issue on RAW/WAW hazards, and it drives registered read selects for both read ports. A round-robin arbiter shares the single RF write port between the ALU and MEM writeback sources. It sits between decode/issue and the register file, and owns every RF read select and write strobe.

## Interface
- DW, 32, register data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  issue request from decode
- iss_ready  out  1  issue accepted this cycle when iss_valid & iss_ready
- iss_rs  in  5  source register A
- iss_rt  in  5  source register B
- iss_rd  in  5  destination register
- iss_we  in  1  instruction writes iss_rd
- rd_valid  out  1  rd_sel_a/b hold an accepted issue's operands (one cycle)
- rd_sel_a  out  5  read mux select, port A
- rd_sel_b  out  5  read mux select, port B
- wb0_valid / wb0_ready  in / out  1  ALU writeback handshake
- wb0_rd  in  5; wb0_data  in  DW
- wb1_valid / wb1_ready  in / out  1  MEM writeback handshake
- wb1_rd  in  5; wb1_data  in  DW
- rf_we  out  1  RF write strobe
- rf_waddr  out  5  RF write address
- rf_wdata  out  DW  RF write data
- busy_vec  out  32  scoreboard, bit n = register n has a pending write
- idle  out  1  busy_vec == 0
- err  out  1  sticky, writeback to a non-busy nonzero register

## Operation
- Scoreboard: busy[31:0]. busy[0] is hardwired to 0.
- hazard = (rs!=0 & busy[rs]) | (rt!=0 & busy[rt]) | (iss_we & rd!=0 & busy[rd]).
- iss_ready = !hazard. It is combinational from the current busy state and does not depend on iss_valid.
- Accept (iss_valid & iss_ready):
  - rd_sel_a <= rs, rd_sel_b <= rt, rd_valid <= 1.
  - If iss_we & rd!=0, busy[rd] <= 1.
- No accept: rd_valid <= 0; rd_sel_a/b hold their values.
- Arbiter: the pointer ptr selects the preferred source (0 = wb0).
  - Exactly one source valid: that source is granted.
  - Both valid: the source named by ptr is granted.
  - After any grant, ptr <= the other source.
  - wbX_ready = grant to X, combinational, at most one per cycle.
- Grant edge:
  - rf_we <= (rd!=0), rf_waddr <= rd, rf_wdata <= data.
  - busy[rd] <= 0.
  - If rd!=0 & !busy[rd], err <= 1. busy is unchanged in that case.
- No grant: rf_we <= 0; rf_waddr/rf_wdata hold their values.
- Writeback to r0 is accepted (ready asserts) and discarded: rf_we stays 0, no err.
- Set and clear of the same register in one cycle cannot occur, because WAW stalls issue while busy. If it does occur, clear wins.
- A waiting source holds wbX_valid and its data stable until granted. The arbiter never drops a request.

## Timing
- Reset (async assert, sync release) sets all outputs and state to 0: busy=0, rd_valid=0, rd_sel_a/b=0, rf_we=0, rf_waddr=0, rf_wdata=0, ptr=0, err=0. idle=1 during reset.
- Reset mid-operation discards all pending busy bits and any staged write. rf_we drops immediately.
- Issue latency: accept at edge N; rd_sel/rd_valid are valid in cycle N+1. RF read data is combinational from the mux in the same cycle.
- Writeback: grant at edge N clears busy at N. rf_we is high in cycle N+1, and the RF captures the data at edge N+1.
- RAW release: a stalled consumer sees iss_ready=1 in cycle N+1. If it is accepted at edge N+1, its operands are read in cycle N+2 after the RF write. No combinational bypass exists.
- Back-to-back grants: one write per cycle sustained. Continuous dual requests alternate wb0, wb1, wb0, ...
- idle follows busy_vec combinationally.

## Test plan
- Reset: drive rst_n=0 mid-run with busy_vec=0x0000_0020 -> all outputs 0 immediately, idle=1, iss_ready=1 for any operands.
- RAW stall: issue rd=5 we=1 (busy_vec=0x20), then rs=5 -> iss_ready=0. wb0 rd=5 data=0xDEADBEEF granted at edge N -> iss_ready=1 in N+1. rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1. Consumer rd_sel_a=5 in N+2.
- WAW: busy[7]=1, issue rd=7 we=1 rs=rt=0 -> stalled until busy[7] clears. Then accepted, and busy[7] is set again.
- Arbitration: wb0 rd=3 and wb1 rd=4 both valid from reset -> grant wb0 first, then wb1. rf_waddr sequence 3,4 on consecutive cycles. A second simultaneous pair is granted wb0 then wb1 again.
- r0: issue rd=0 we=1 -> busy_vec unchanged. wb1 rd=0 -> wb1_ready=1, rf_we stays 0, err=0.
- Spurious writeback: wb0 rd=9 with busy[9]=0 -> rf_we=1 with rf_waddr=9, err=1 and stays 1 until reset.
